multiword_add_seq: RTL

- Sequencer that performs wide (WORDS×WIDTH-bit) add/subtract by time-multiplexing a single WIDTH-bit ripple-carry slice adder, one slice per clock, LSB slice first.
- Carry between slices is held in a register.
- Sits in front of the shared combinational adder datapath. Trades latency (WORDS cycles) for area versus a full-width ripple chain.

---
 rtl/multiword_add_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - wide add/subtract sequenced through one WIDTH-bit slice adder
module multiword_add_seq #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sub,
    input  logic [WIDTH*WORDS-1:0]   a,
    input  logic [WIDTH*WORDS-1:0]   b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*WORDS-1:0]   sum,
    output logic                     cout,
    output logic                     ovf
);

    localparam int N    = WIDTH * WORDS;
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;       // already inverted for subtraction
    logic [N-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic              w_capture;
    logic              w_last;
    logic [WIDTH-1:0]  w_a_slice;
    logic [WIDTH-1:0]  w_b_slice;
    logic [WIDTH:0]    w_slice_full;
    logic [N-1:0]      w_sum_next;

    assign w_last = (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, capture strobe and status outputs
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Select the operand slices addressed by the slice counter
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_slice = r_a[i*WIDTH +: WIDTH];
                w_b_slice = r_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // The single shared ripple-carry slice adder
    assign w_slice_full = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{WIDTH{1'b0}}, r_carry};

    // Merge the fresh slice result into the held sum; other slices keep their value
    always_comb begin
        w_sum_next = r_sum;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sum_next[i*WIDTH +: WIDTH] = w_slice_full[WIDTH-1:0];
            end
        end
    end

    // Operand capture, per-slice accumulation and final flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_capture) begin
            // a - b - cin == a + ~b + (1 - cin), so carry-in is cin ^ sub
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_slice_full[WIDTH];
            r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
            if (w_last) begin
                r_cout <= w_slice_full[WIDTH];
                r_ovf  <= (r_a[N-1] == r_b[N-1]) && (w_slice_full[WIDTH-1] != r_a[N-1]);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
